dmem_responder: RTL and testbench

Off-chip data memory model that answers the data cache's line-fill and write-back requests. It is the responder end of the 256-bit memory interface that the CPU top exposes as `mem_*`. It accepts one request at a time, waits a fixed latency, then pulses an acknowledge, returning read data on that same cycle. It is instantiated beside the CPU in the testbench and system top.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Off-chip data memory model that serves 256-bit line reads
//                and writes. It takes one request at a time and acknowledges
//                it after a fixed latency. Read data is returned on the ack
//                cycle.
//                Optional macro DMEM_FAST_WRITE_EN: when it is defined, writes
//                acknowledge one cycle after acceptance. Reads always take
//                LATENCY cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int LATENCY = 10,   // 1..255
    parameter int DEPTH   = 512   // power of two, >= 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               req_write_q, req_write_d;
    logic [c_IDX_W-1:0] req_idx_q, req_idx_d;
    logic [255:0]       req_data_q, req_data_d;
    logic               ack_q, ack_d;
    logic [255:0]       rdata_q, rdata_d;

    logic [255:0]       mem_q [DEPTH];

    logic [c_IDX_W-1:0] w_idx;
    logic [7:0]         w_cnt_load;
    logic               w_commit;
    logic               w_mem_we;
    logic               w_unused_addr;

    // The line index uses only the address bits above the 32-byte offset.
    // Higher bits alias the line.
    assign w_idx         = addr_i[c_IDX_W+4:5];
    assign w_unused_addr = ^{addr_i[31:c_IDX_W+5], addr_i[4:0]};

`ifdef DMEM_FAST_WRITE_EN
    // A write loads a zero count, so it finishes after a single WAIT cycle.
    assign w_cnt_load = write_i ? 8'd0 : c_CNT_INIT;
`else
    assign w_cnt_load = c_CNT_INIT;
`endif

    // State register, countdown and request capture, with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= 8'd0;
            req_write_q <= 1'b0;
            req_idx_q   <= '0;
            req_data_q  <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_write_q <= req_write_d;
            req_idx_q   <= req_idx_d;
            req_data_q  <= req_data_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic: accept, count down, acknowledge.
    // The ACK cycle also serves as the acceptance slot. A request that is
    // still held when ack is seen is taken on the edge that leaves ACK.
    // A LATENCY of 1 loads a zero count, so the one WAIT cycle lands ack at n+1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_write_d = req_write_q;
        req_idx_d   = req_idx_q;
        req_data_d  = req_data_q;
        case (state_q)
            c_ST_IDLE, c_ST_ACK: begin
                state_d = c_ST_IDLE;
                if (enable_i) begin
                    state_d     = c_ST_WAIT;
                    cnt_d       = w_cnt_load;
                    req_write_d = write_i;
                    req_idx_d   = w_idx;
                    req_data_d  = data_i;
                end
            end
            c_ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = c_ST_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Output logic: the edge that enters ACK raises ack.
    // On that same edge a read loads data_o and a write commits.
    always_comb begin
        w_commit = (state_q == c_ST_WAIT) && (cnt_q == 8'd0);
        ack_d    = w_commit;
        w_mem_we = w_commit && req_write_q;
        rdata_d  = rdata_q;
        if (w_commit && !req_write_q) begin
            rdata_d = mem_q[req_idx_q];
        end
    end

    // Line storage. It is never cleared. A commit that coincides with
    // reset assertion is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
        end else if (w_mem_we) begin
            mem_q[req_idx_q] <= req_data_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed vector bench for dmem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 10;
`ifdef DMEM_FAST_WRITE_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = LAT;
`endif

    localparam logic [255:0] c_A5 = {32{8'hA5}};
    localparam logic [255:0] c_P1 = {8{32'hDEADBEEF}};
    localparam logic [255:0] c_P2 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] c_P3 = {16{16'h5A3C}};

    logic         clk;
    logic         rst;
    logic         enable;
    logic         write;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack_o;
    logic [255:0] data_o;

    int n_cmp = 0;
    int n_err = 0;

    dmem_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .write_i  (write),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Called #1 after the acceptance edge (edge 0), or after edge 'start'.
    // Returns the edge number of the first ack, or -1 if no ack arrives within the bound.
    task automatic wait_ack(input int start, output int lat, output logic [255:0] rd);
        lat = -1;
        rd  = 'x;
        for (int k = start + 1; k <= start + 300; k++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                lat = k;
                rd  = data_o;
                break;
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                          output int lat, output logic [255:0] rd);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        @(posedge clk); #1;
        wait_ack(0, lat, rd);
        enable = 1'b0;
    endtask

    initial begin
        int           lat, lat2, acks;
        logic [255:0] rd;

        vecs[0] = '{1'b1, 32'h0000_0060, c_A5, 256'h0};
        vecs[1] = '{1'b0, 32'h0000_0060, '0,   c_A5};
        vecs[2] = '{1'b1, 32'h0000_0040, c_P1, c_A5};
        vecs[3] = '{1'b0, 32'h0000_405F, '0,   c_P1};
        vecs[4] = '{1'b1, 32'h0000_0020, c_P2, c_P1};
        vecs[5] = '{1'b0, 32'h0000_4020, '0,   c_P2};
        vecs[6] = '{1'b0, 32'hFFFF_C060, '0,   c_A5};
        vecs[7] = '{1'b1, 32'h0000_3FE0, c_P3, c_A5};
        vecs[8] = '{1'b0, 32'h0000_3FE0, '0,   c_P3};

        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        rst    = 1'b0;

        // Assert reset between edges. The outputs must clear without a clock.
        #3 rst = 1'b1;
        #1;
        chk("reset_ack", {255'b0, ack_o}, 256'd0);
        chk("reset_data", data_o, 256'd0);
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        chk("reset_hold_no_ack", 256'(acks), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven single requests, with one idle cycle between them.
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].wr, vecs[i].a, vecs[i].d, lat, rd);
            chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].wr ? WR_LAT : LAT));
            chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            @(posedge clk); #1;
        end

        // Enable dropped during WAIT: the captured read still completes.
        enable = 1'b1; write = 1'b0; addr = 32'h60; wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0; addr = 32'h40;
        wait_ack(2, lat, rd);
        chk("drop_en_latency", 256'(lat), 256'(LAT));
        chk("drop_en_data", rd, c_A5);
        @(posedge clk); #1;

        // Back-to-back: a write, then a read of the same line with enable held high.
        enable = 1'b1; write = 1'b1; addr = 32'h80; wdata = 256'h1234;
        @(posedge clk); #1;
        wait_ack(0, lat, rd);
        chk("b2b_write_latency", 256'(lat), 256'(WR_LAT));
        chk("b2b_write_data_hold", rd, c_A5);
        write = 1'b0; wdata = '0;
        wait_ack(0, lat2, rd);
        enable = 1'b0;
        chk("b2b_read_gap", 256'(lat2), 256'(LAT + 1));
        chk("b2b_read_data", rd, 256'h1234);
        @(posedge clk); #1;

        // Reset during the WAIT of a write: the write is discarded.
        enable = 1'b1; write = 1'b1; addr = 32'h20; wdata = 256'hFF;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        enable = 1'b0; write = 1'b0; wdata = '0;
        chk("midrst_ack", {255'b0, ack_o}, 256'd0);
        chk("midrst_data", data_o, 256'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        chk("midrst_no_spurious_ack", 256'(acks), 256'd0);
        do_req(1'b0, 32'h20, '0, lat, rd);
        chk("midrst_read_latency", 256'(lat), 256'(LAT));
`ifdef DMEM_FAST_WRITE_EN
        chk("midrst_read_data", rd, 256'hFF);
`else
        chk("midrst_read_data", rd, c_P2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
